imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-serial program loader: assembles MSB-first 32-bit words from a byte stream,
// writes them to instruction memory and steers the fetch-stage PC around the load.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [6:0]  num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        WE,
  output logic [31:0] W_Ins,
  output logic [1:0]  bout,
  output logic [31:0] newPC,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] CAP = (MAX_WORDS > 127) ? 7'd127 : 7'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_RECV, S_WRITE, S_ADVANCE, S_FINAL, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic [6:0]  wcnt_q, wcnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wins_q, wins_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      wins_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      wins_q  <= wins_d;
    end
  end

  // Byte handshake: a byte transfers on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready depends on state only, never on byte_valid.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    wins_d  = wins_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = (num_words > CAP) ? CAP : num_words;
          wcnt_d  = '0;
          state_d = S_REWIND;
        end
      end
      S_REWIND: begin
        addr_d  = '0;
        bcnt_d  = '0;
        state_d = (count_q != 7'd0) ? S_RECV : S_FINAL;
      end
      S_RECV: begin
        if (byte_valid) begin
          wins_d = {wins_q[23:0], byte_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_ADVANCE;
      S_ADVANCE: begin
        addr_d  = addr_q + 32'd4;
        wcnt_d  = wcnt_q + 7'd1;
        state_d = ((wcnt_q + 7'd1) == count_q) ? S_FINAL : S_RECV;
      end
      S_FINAL: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // WE and a PC load come from disjoint states, so they can never coincide.
  always_comb begin
    byte_ready = 1'b0;
    WE         = 1'b0;
    bout       = 2'b00;
    newPC      = '0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    unique case (state_q)
      S_IDLE:    ;
      S_REWIND:  bout = 2'b01;
      S_RECV:    byte_ready = 1'b1;
      S_WRITE:   WE = 1'b1;
      S_ADVANCE: begin
        bout  = 2'b01;
        newPC = addr_q + 32'd4;
      end
      S_FINAL:   bout = 2'b01;
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  assign W_Ins = wins_q;

endmodule
